sar_step_gate: RTL and testbench



---
 rtl/sar_step_gate.sv | 126 ++++++++++++
 tb/tb_sar_step_gate.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_step_gate.sv
// rtl/sar_step_gate.sv - SAR conversion sequencer: sample window, then MSB-first gated one-hot bit strobes
// Optional feature macro: SAR_STEP_GATE_CONT_EN (DONE re-enters SAMPLE while cont is high).
module sar_step_gate #(
  parameter int NBITS      = 8,
  parameter int DIV        = 2,
  parameter int SAMPLE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     hold,
  input  logic                     cont,
  input  logic [NBITS-1:0]         en_mask,
  output logic                     sample,
  output logic [NBITS-1:0]         bit_en,
  output logic [$clog2(NBITS)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done
);
  localparam int IW = $clog2(NBITS);
  localparam int PW = $clog2(DIV) + 1;
  localparam int SW = $clog2(SAMPLE_CYC) + 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_CYC - 1);
  localparam logic [IW-1:0] I_MSB  = IW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [SW-1:0]    r_scnt, w_scnt_nx;
  logic [PW-1:0]    r_pcnt, w_pcnt_nx;
  logic [IW-1:0]    r_idx, w_idx_nx;
  logic             r_sample, r_busy, r_done;
  logic [NBITS-1:0] r_bit_en;
  logic             w_freeze;
  logic             w_cont_go;
  logic [NBITS-1:0] w_step;

`ifdef SAR_STEP_GATE_CONT_EN
  assign w_cont_go = cont;
`else
  logic w_unused_cont;
  assign w_unused_cont = cont;
  assign w_cont_go     = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_scnt_nx  = r_scnt;
    w_pcnt_nx  = r_pcnt;
    w_idx_nx   = r_idx;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = SAMPLE;
          w_scnt_nx  = '0;
        end
      end
      SAMPLE: begin
        if (r_scnt == S_LAST) begin
          w_state_nx = CONV;
          w_pcnt_nx  = '0;
          w_idx_nx   = I_MSB;
        end else begin
          w_scnt_nx = r_scnt + 1'b1;
        end
      end
      CONV: begin
        // hold freezes the phase position; the remaining cycles run on release
        if (!hold) begin
          if (r_pcnt == P_LAST) begin
            w_pcnt_nx = '0;
            if (r_idx == '0) w_state_nx = DONE;
            else             w_idx_nx   = r_idx - 1'b1;
          end else begin
            w_pcnt_nx = r_pcnt + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nx = w_cont_go ? SAMPLE : IDLE;
        w_scnt_nx  = '0;
        w_idx_nx   = '0;
      end
      default: w_state_nx = IDLE;
    endcase
    if (abort) begin
      w_state_nx = IDLE;
      w_scnt_nx  = '0;
      w_pcnt_nx  = '0;
      w_idx_nx   = '0;
    end
  end

  assign w_freeze = (r_state == CONV) && hold;
  assign w_step   = {{(NBITS-1){1'b0}}, 1'b1} << w_idx_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_scnt   <= '0;
      r_pcnt   <= '0;
      r_idx    <= '0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bit_en <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_scnt   <= w_scnt_nx;
      r_pcnt   <= w_pcnt_nx;
      r_idx    <= w_idx_nx;
      r_sample <= (w_state_nx == SAMPLE);
      r_busy   <= (w_state_nx == SAMPLE) || (w_state_nx == CONV);
      r_done   <= (w_state_nx == DONE);
      r_bit_en <= ((w_state_nx == CONV) && !w_freeze) ? (w_step & en_mask) : '0;
    end
  end

  assign sample  = r_sample;
  assign bit_en  = r_bit_en;
  assign bit_idx = r_idx;
  assign busy    = r_busy;
  assign done    = r_done;
endmodule

// File: tb/tb_sar_step_gate.sv
// tb/tb_sar_step_gate.sv - vector table, corner sequences and random model check for sar_step_gate
module tb_sar_step_gate;
  localparam int N = 8;
  localparam int D = 2;
  localparam int S = 2;
`ifdef SAR_STEP_GATE_CONT_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, abort, hold, cont;
  logic [7:0] en_mask;
  logic       sample, busy, done;
  logic [7:0] bit_en;
  logic [2:0] bit_idx;

  int n_tests = 0;
  int n_fail  = 0;

  sar_step_gate #(.NBITS(N), .DIV(D), .SAMPLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold), .cont(cont),
    .en_mask(en_mask), .sample(sample), .bit_en(bit_en), .bit_idx(bit_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] mask;
    int hold_at; int hold_len; int abort_at; int start2; int chk;
    logic e_sample; logic [7:0] e_be; int e_idx; logic e_busy; logic e_done; int e_ndone;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] m, input int ha, input int hl, input int ab, input int s2,
                     input int c, input logic es, input logic [7:0] eb, input int ei,
                     input logic ebu, input logic ed, input int en);
    vec_t v;
    v.mask = m; v.hold_at = ha; v.hold_len = hl; v.abort_at = ab; v.start2 = s2; v.chk = c;
    v.e_sample = es; v.e_be = eb; v.e_idx = ei; v.e_busy = ebu; v.e_done = ed; v.e_ndone = en;
    vecs.push_back(v);
  endtask

  task automatic clean_idle();
    start = 1'b0; hold = 1'b0; cont = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic s, d, b;
    logic [7:0] be;
    logic [2:0] ix;
    int nd;
    nd = 0; s = 0; d = 0; b = 0; be = 0; ix = 0;
    for (int c = 0; c <= v.chk; c++) begin
      start   = (c == 0) || (c == v.start2);
      hold    = (c >= v.hold_at) && (c < v.hold_at + v.hold_len);
      abort   = (c == v.abort_at);
      cont    = 1'b0;
      en_mask = v.mask;
      @(negedge clk);
      if (done) nd++;
      if (c == v.chk) begin s = sample; be = bit_en; b = busy; d = done; ix = bit_idx; end
      @(posedge clk); #1;
    end
    check($sformatf("vec%0d.sample", k), 32'(s), 32'(v.e_sample));
    check($sformatf("vec%0d.bit_en", k), 32'(be), 32'(v.e_be));
    check($sformatf("vec%0d.busy", k), 32'(b), 32'(v.e_busy));
    check($sformatf("vec%0d.done", k), 32'(d), 32'(v.e_done));
    if (v.e_idx >= 0) check($sformatf("vec%0d.bit_idx", k), 32'(ix), 32'(v.e_idx));
    if (v.e_ndone >= 0) check($sformatf("vec%0d.ndone", k), 32'(nd), 32'(v.e_ndone));
    clean_idle();
  endtask

  // reference model: position t counts non-held cycles since start
  bit   m_act;
  int   m_t;
  bit   m_held;
  logic [7:0] m_mask;

  task automatic run_random(input int ncyc);
    logic e_sample, e_busy, e_done, in_conv;
    logic [7:0] e_be, one;
    int e_idx;
    m_act = 0; m_t = 0; m_held = 0; m_mask = 0;
    en_mask = 8'h00;
    for (int c = 0; c < ncyc; c++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 63) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      cont  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) en_mask = 8'($urandom);
      @(negedge clk);
      in_conv  = m_act && (m_t >= S) && (m_t < S + N*D);
      e_sample = m_act && (m_t < S);
      e_busy   = m_act && (m_t < S + N*D);
      e_done   = m_act && (m_t == S + N*D);
      e_idx    = in_conv ? (N - 1 - (m_t - S) / D) : 0;
      one      = 8'd1;
      e_be     = (in_conv && !m_held) ? ((one << e_idx) & m_mask) : 8'h00;
      check("rand.outputs", {19'd0, sample, bit_en, bit_idx, busy, done},
            {19'd0, e_sample, e_be, 3'(e_idx), e_busy, e_done});
      check("rand.onehot", 32'($countones(bit_en) <= 1), 32'd1);
      m_held = in_conv && hold && !abort;
      m_mask = en_mask;
      if (abort) m_act = 0;
      else if (!m_act) begin
        if (start) begin m_act = 1; m_t = 0; end
      end else if (e_done) begin
        if (CONT_EN && cont) m_t = 0;
        else m_act = 0;
      end else if (!(in_conv && hold)) m_t++;
      @(posedge clk); #1;
    end
    clean_idle();
  endtask

  initial begin
    int dq[$];
    logic s20;
    rst_n = 1'b0; start = 0; abort = 0; hold = 0; cont = 0; en_mask = 8'h00;
    #12;
    check("reset.outputs", {19'd0, sample, bit_en, bit_idx, busy, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    add(8'hFF, -1, 0, -1, -1,  0, 0, 8'h00,  0, 0, 0, 0);
    add(8'hFF, -1, 0, -1, -1,  1, 1, 8'h00, -1, 1, 0, 0);
    add(8'hFF, -1, 0, -1, -1,  2, 1, 8'h00, -1, 1, 0, 0);
    add(8'hFF, -1, 0, -1, -1,  3, 0, 8'h80,  7, 1, 0, 0);
    add(8'hFF, -1, 0, -1, -1,  4, 0, 8'h80,  7, 1, 0, 0);
    add(8'hFF, -1, 0, -1, -1,  5, 0, 8'h40,  6, 1, 0, 0);
    add(8'hFF, -1, 0, -1, -1, 18, 0, 8'h01,  0, 1, 0, 0);
    add(8'hFF, -1, 0, -1, -1, 19, 0, 8'h00, -1, 0, 1, 1);
    add(8'hFF, -1, 0, -1, -1, 20, 0, 8'h00,  0, 0, 0, 1);
    add(8'hA5, -1, 0, -1, -1,  5, 0, 8'h00,  6, 1, 0, 0);
    add(8'hA5, -1, 0, -1, -1,  7, 0, 8'h20,  5, 1, 0, 0);
    add(8'hA5, -1, 0, -1, -1, 17, 0, 8'h01,  0, 1, 0, 0);
    add(8'hA5, -1, 0, -1, -1, 19, 0, 8'h00, -1, 0, 1, 1);
    add(8'hFF,  6, 3, -1, -1,  6, 0, 8'h40,  6, 1, 0, 0);
    add(8'hFF,  6, 3, -1, -1,  7, 0, 8'h00,  6, 1, 0, 0);
    add(8'hFF,  6, 3, -1, -1,  9, 0, 8'h00,  6, 1, 0, 0);
    add(8'hFF,  6, 3, -1, -1, 11, 0, 8'h20,  5, 1, 0, 0);
    add(8'hFF,  6, 3, -1, -1, 19, 0, 8'h02,  1, 1, 0, 0);
    add(8'hFF,  6, 3, -1, -1, 21, 0, 8'h01,  0, 1, 0, 0);
    add(8'hFF,  6, 3, -1, -1, 22, 0, 8'h00, -1, 0, 1, 1);
    add(8'hFF, -1, 0, 10, -1, 11, 0, 8'h00,  0, 0, 0, 0);
    add(8'hFF, -1, 0, 10, 12, 13, 1, 8'h00, -1, 1, 0, 0);
    add(8'hFF, -1, 0, 10, 12, 31, 0, 8'h00, -1, 0, 1, 1);
    add(8'hFF, -1, 0, -1,  5, 19, 0, 8'h00, -1, 0, 1, 1);
    add(8'hFF, -1, 0, -1,  5, 40, 0, 8'h00,  0, 0, 0, 1);
    foreach (vecs[k]) run_vec(k, vecs[k]);

    // asynchronous reset in the middle of a conversion
    en_mask = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (c == 7) check("rst.busy_before", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst.async_clear", {19'd0, sample, bit_en, bit_idx, busy, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.stays_idle", {19'd0, sample, bit_en, bit_idx, busy, done}, 32'd0);
    @(posedge clk); #1;

    // continuous mode: back-to-back only when the option is built in
    s20 = 1'b0;
    cont = 1'b1; en_mask = 8'hFF;
    for (int c = 0; c <= 60; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (done) dq.push_back(c);
      if (c == 20) s20 = sample;
      @(posedge clk); #1;
    end
`ifdef SAR_STEP_GATE_CONT_EN
    check("cont.ndone", 32'(dq.size()), 32'd3);
    if (dq.size() == 3) begin
      check("cont.done0", 32'(dq[0]), 32'd19);
      check("cont.done1", 32'(dq[1]), 32'd38);
      check("cont.done2", 32'(dq[2]), 32'd57);
    end
    check("cont.sample20", 32'(s20), 32'd1);
`else
    check("cont.ndone", 32'(dq.size()), 32'd1);
    if (dq.size() == 1) check("cont.done0", 32'(dq[0]), 32'd19);
    check("cont.sample20", 32'(s20), 32'd0);
`endif
    clean_idle();

    run_random(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
